// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: horizontal/vertical counters with per-axis phase FSMs
// and registered sync, blanking, coordinate and start-of-line/frame outputs.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0,
    parameter int CW       = 10
) (
    input  logic          clk_in,
    input  logic          reset,
    input  logic          enable,
    output logic          hsync,
    output logic          vsync,
    output logic          active,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Each phase ends on the count just before the next phase boundary.
    localparam logic [CW-1:0] H_END_ACT  = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] H_END_FP   = CW'(H_ACTIVE + H_FP - 1);
    localparam logic [CW-1:0] H_END_SYNC = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_END_ACT  = CW'(V_ACTIVE - 1);
    localparam logic [CW-1:0] V_END_FP   = CW'(V_ACTIVE + V_FP - 1);
    localparam logic [CW-1:0] V_END_SYNC = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);

    typedef enum logic [1:0] {PH_ACTIVE, PH_FRONT, PH_SYNC, PH_BACK} phase_t;

    logic [CW-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    phase_t        h_ph_q, h_ph_d, v_ph_q, v_ph_d;
    logic          h_wrap;

    logic          hsync_q, hsync_d, vsync_q, vsync_d, active_q, active_d;
    logic [CW-1:0] x_q, x_d, y_q, y_d;
    logic          line_start_q, line_start_d, frame_start_q, frame_start_d;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            h_ph_q  <= PH_ACTIVE;
            v_ph_q  <= PH_ACTIVE;
        end else if (enable) begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            h_ph_q  <= h_ph_d;
            v_ph_q  <= v_ph_d;
        end
    end

    always_comb begin
        h_wrap  = (h_cnt_q == H_LAST);
        h_cnt_d = h_wrap ? '0 : h_cnt_q + CW'(1);
        v_cnt_d = v_cnt_q;
        if (h_wrap) begin
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CW'(1);
        end
    end

    always_comb begin
        h_ph_d = h_ph_q;
        case (h_ph_q)
            PH_ACTIVE: if (h_cnt_q == H_END_ACT)  h_ph_d = PH_FRONT;
            PH_FRONT:  if (h_cnt_q == H_END_FP)   h_ph_d = PH_SYNC;
            PH_SYNC:   if (h_cnt_q == H_END_SYNC) h_ph_d = PH_BACK;
            PH_BACK:   if (h_wrap)                h_ph_d = PH_ACTIVE;
            default:                              h_ph_d = PH_ACTIVE;
        endcase

        // The vertical phase only moves on the edge that ends a line.
        v_ph_d = v_ph_q;
        if (h_wrap) begin
            case (v_ph_q)
                PH_ACTIVE: if (v_cnt_q == V_END_ACT)  v_ph_d = PH_FRONT;
                PH_FRONT:  if (v_cnt_q == V_END_FP)   v_ph_d = PH_SYNC;
                PH_SYNC:   if (v_cnt_q == V_END_SYNC) v_ph_d = PH_BACK;
                PH_BACK:   if (v_cnt_q == V_LAST)     v_ph_d = PH_ACTIVE;
                default:                              v_ph_d = PH_ACTIVE;
            endcase
        end
    end

    always_comb begin
        hsync_d       = (h_ph_q == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
        vsync_d       = (v_ph_q == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
        active_d      = (h_ph_q == PH_ACTIVE) && (v_ph_q == PH_ACTIVE);
        x_d           = h_cnt_q;
        y_d           = v_cnt_q;
        line_start_d  = (h_cnt_q == '0);
        frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
    end

    // Outputs describe the pre-edge position, one clock behind the counters.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            active_q      <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else if (enable) begin
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            active_q      <= active_d;
            x_q           <= x_d;
            y_q           <= y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign active      = active_q;
    assign x           = x_q;
    assign y           = y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
- REQ-001: The block SHALL provide parameter H_ACTIVE, default 640, visible pixels per line.
- REQ-002: The block SHALL provide parameter H_FP, default 16, horizontal front porch in pixel clocks.
- REQ-003: The block SHALL provide parameter H_SYNC, default 96, horizontal sync width in pixel clocks.
- REQ-004: The block SHALL provide parameter H_BP, default 48, horizontal back porch in pixel clocks.
- REQ-005: The block SHALL provide parameter V_ACTIVE, default 480, visible lines per frame.
- REQ-006: The block SHALL provide parameter V_FP, default 10, vertical front porch in lines.
- REQ-007: The block SHALL provide parameter V_SYNC, default 2, vertical sync width in lines.
- REQ-008: The block SHALL provide parameter V_BP, default 33, vertical back porch in lines.
- REQ-009: The block SHALL provide parameter SYNC_POL, default 0; 0 means sync asserted low, 1 means asserted high.
- REQ-010: The block SHALL provide parameter CW, default 10, counter and coordinate width; H_TOTAL (sum of H_*) and V_TOTAL (sum of V_*) SHALL each be at most 2^CW.
- REQ-011: The block SHALL have these ports:
  - clk_in, input, 1: pixel clock (25.2 MHz from the board clock generator); the block's only clock.
  - reset, input, 1: asynchronous reset, active-high.
  - enable, input, 1: advance timing when high; hold all state when low.
  - hsync, output, 1: horizontal sync, polarity per SYNC_POL.
  - vsync, output, 1: vertical sync, polarity per SYNC_POL.
  - active, output, 1: high during visible pixels.
  - x, output, CW: current horizontal pixel coordinate.
  - y, output, CW: current line coordinate.
  - line_start, output, 1: one-cycle pulse at h=0.
  - frame_start, output, 1: one-cycle pulse at h=0, v=0.

Function
- REQ-012: The block SHALL keep h_cnt in 0..H_TOTAL-1 and v_cnt in 0..V_TOTAL-1, both CW bits wide.
- REQ-013: On each rising clk_in edge with enable=1, h_cnt SHALL increment; when h_cnt=H_TOTAL-1 it SHALL wrap to 0 and v_cnt SHALL advance.
- REQ-014: v_cnt SHALL increment only on an h_cnt wrap, and SHALL wrap from V_TOTAL-1 to 0 on that same edge.
- REQ-015: The block SHALL hold per-axis phase FSMs with states ACTIVE, FRONT, SYNC, BACK:
  - horizontal transitions SHALL occur at h_cnt = H_ACTIVE, H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC and H_TOTAL (wrap to ACTIVE);
  - vertical transitions SHALL occur likewise on v_cnt, changing only on h_cnt wrap edges.
- REQ-016: All outputs SHALL be registered, sampled on the same enabled edge at which the counters advance.
- REQ-017: After each enabled edge, the outputs SHALL describe the pre-edge counter values (h,v); latency is one clock from counter value to output.
- REQ-018: active SHALL be high iff h < H_ACTIVE and v < V_ACTIVE.
- REQ-019: x SHALL equal h and y SHALL equal v, including during blanking.
- REQ-020: hsync SHALL be asserted iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (default 656..751).
- REQ-021: vsync SHALL be asserted iff V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (default 490..491), for whole lines.
- REQ-022: line_start SHALL be 1 iff h=0; frame_start SHALL be 1 iff h=0 and v=0.
- REQ-023: When enable=0, counters, FSMs and all outputs SHALL hold their values, including line_start and frame_start.
- REQ-024: With enable held high, frame period SHALL be H_TOTAL*V_TOTAL clocks (default 800*525 = 420000).

Reset
- REQ-025: reset=1 SHALL immediately and asynchronously set:
  - h_cnt=0, v_cnt=0, both FSMs to ACTIVE;
  - x=0, y=0, active=0, line_start=0, frame_start=0;
  - hsync and vsync to deasserted level (=~SYNC_POL).
- REQ-026: Reset asserted mid-frame SHALL discard position.
- REQ-027: The first enabled edge after reset release SHALL output frame_start=1, line_start=1, active=1, x=0, y=0.

Verification
- REQ-028: Assert reset mid-line with enable=1 -> outputs go to reset values without a clock edge; after release, first enabled edge gives frame_start=1, x=0, y=0.
- REQ-029: Run one line -> hsync low for exactly 96 consecutive clocks starting 656 clocks after line_start; active high for 640 clocks; line_start period 800.
- REQ-030: Run two full frames -> frame_start pulses exactly 420000 clocks apart; vsync low for exactly 1600 clocks starting at x=0, y=490.
- REQ-031: Toggle enable pseudo-randomly -> output sequence equals the always-enabled sequence with repeats during enable=0 cycles; no pulse is lost or duplicated.
- REQ-032: At boundary x=799, y=524 -> next enabled edge gives x=0, y=0, frame_start=1; at x=799, y=479 -> next gives y=480, active=0.
- REQ-033: Run with SYNC_POL=1 -> sync levels inverted and all timing identical to REQ-029 and REQ-030.
